alu_pipe_ctrl: RTL and testbench

Parametrised, registered successor to the board-level ALU front end. It loads operand A, operand B and a 6-bit opcode from a shared data bus under a select code and a load strobe, and computes a registered result with status flags. It also supports an accumulate mode that feeds the last result back into A. It sits between the switch/button inputs and the LED/display outputs and is sized by parameter for wider datapaths.

---
 rtl/alu_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_pipe_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_ctrl.sv
// Registered ALU front end: operands and opcode load from a shared bus on a
// load-strobe rising edge; result and flags register one edge later.
module alu_pipe_ctrl #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = 3
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_dato,
  input  logic [1:0]         i_sel,
  input  logic               i_load,
  output logic [NB_DATA-1:0] o_result,
  output logic [2:0]         o_flags,
  output logic               o_valid
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               load_q, load_d;
  logic               calc_q, calc_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic [2:0]         flags_q, flags_d;
  logic               valid_q, valid_d;

  logic               load_event;
  logic [NB_DATA:0]   sum, diff;
  logic [NB_SHAMT-1:0] shamt;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_cy, alu_ovf;

  assign load_event = i_load & ~load_q;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    load_d = i_load;
    calc_d = load_event;
    if (load_event) begin
      case (i_sel)
        2'b00:   a_d  = i_dato;
        2'b01:   b_d  = i_dato;
        2'b10:   op_d = i_dato[NB_OP-1:0];
        default: a_d  = result_q;
      endcase
    end
  end

  // Top bit of the widened difference is the unsigned borrow.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    shamt   = b_q[NB_SHAMT-1:0];
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[NB_DATA-1:0];
        alu_cy  = sum[NB_DATA];
        alu_ovf = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) &&
                  (sum[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res = diff[NB_DATA-1:0];
        alu_cy  = diff[NB_DATA];
        alu_ovf = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) &&
                  (diff[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_SRA:  alu_res = NB_DATA'($signed(a_q) >>> shamt);
      OP_SRL:  alu_res = a_q >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = calc_q;
    if (calc_q) begin
      result_d = alu_res;
      flags_d  = {alu_ovf, alu_cy, (alu_res == '0)};
    end
  end

  // load_q resets high so a strobe held through reset release is ignored.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      load_q   <= 1'b1;
      calc_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 3'b000;
      valid_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      load_q   <= load_d;
      calc_q   <= calc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign o_result = result_q;
  assign o_flags  = flags_q;
  assign o_valid  = valid_q;

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Self-checking bench for alu_pipe_ctrl: directed test-plan cases plus
// randomized loads against an arithmetic reference model.
module tb_alu_pipe_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_dato;
  logic [1:0] i_sel;
  logic       i_load;
  logic [7:0] o_result;
  logic [2:0] o_flags;
  logic       o_valid;

  int tests = 0;
  int errors = 0;

  int m_a, m_b, m_op;
  int exp_res, exp_flags, exp_valid;

  alu_pipe_ctrl #(.NB_DATA(8), .NB_OP(6), .NB_SHAMT(3)) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_dato   (i_dato),
    .i_sel    (i_sel),
    .i_load   (i_load),
    .o_result (o_result),
    .o_flags  (o_flags),
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result and flags from signed/unsigned integer arithmetic.
  function automatic void alu_model(input int a, input int b, input int op,
                                    output int res, output int flags);
    int sa, sb, s, ovf, cy;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    ovf = 0;
    cy  = 0;
    case (op)
      32: begin s = sa + sb; res = (a + b) % 256; cy = (a + b) > 255; ovf = (s > 127) || (s < -128); end
      34: begin s = sa - sb; res = (a - b + 256) % 256; cy = a < b; ovf = (s > 127) || (s < -128); end
      36: res = a & b;
      37: res = a | b;
      38: res = a ^ b;
      39: res = 255 - (a | b);
      3:  res = (sa >>> (b % 8)) & 255;
      2:  res = a >> (b % 8);
      default: res = 0;
    endcase
    flags = ovf * 4 + cy * 2 + ((res == 0) ? 1 : 0);
  endfunction

  always @(negedge clk) begin
    check("o_valid", int'(o_valid), exp_valid);
    check("o_result", int'(o_result), exp_res);
    check("o_flags", int'(o_flags), exp_flags);
  end

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 32;
    exp_res = 0; exp_flags = 0; exp_valid = 0;
  endtask

  task automatic load(input int sel, input int dato, input int hold);
    int r, f;
    @(negedge clk);
    i_sel  = 2'(sel);
    i_dato = 8'(dato);
    i_load = 1'b1;
    @(negedge clk);
    case (sel)
      0: m_a = dato;
      1: m_b = dato;
      2: m_op = dato % 64;
      default: m_a = exp_res;
    endcase
    if (hold == 0) i_load = 1'b0;
    i_sel  = 2'($urandom_range(0, 3));
    i_dato = 8'($urandom_range(0, 255));
    alu_model(m_a, m_b, m_op, r, f);
    @(posedge clk); #1;
    exp_res = r; exp_flags = f; exp_valid = 1;
    @(posedge clk); #1;
    exp_valid = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    i_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input int res, input int flags);
    check({name, "_res"}, int'(o_result), res);
    check({name, "_flags"}, int'(o_flags), flags);
  endtask

  int ops[8] = '{32, 34, 36, 37, 38, 39, 3, 2};

  initial begin
    i_rst = 1'b1; i_load = 1'b0; i_sel = 2'b00; i_dato = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); i_load = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); i_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_idle", 0, 0);

    load(0, 8'h03, 0); load(1, 8'h05, 0); load(2, 8'h20, 0);
    lit("add_3_5", 8'h08, 3'b000);
    load(2, 8'h22, 1);
    lit("sub_3_5", 8'hFE, 3'b010);
    load(2, 8'h20, 0); load(0, 8'h7F, 0); load(1, 8'h01, 2);
    lit("add_ovf", 8'h80, 3'b100);
    load(0, 8'hFF, 0);
    lit("add_carry", 8'h00, 3'b011);
    load(0, 8'h90, 0); load(1, 8'h02, 0); load(2, 8'h03, 0);
    lit("sra", 8'hE4, 0);
    load(2, 8'h02, 0);
    lit("srl", 8'h24, 0);
    load(1, 8'h0A, 0);
    lit("srl_hib", 8'h24, 0);
    load(2, 8'h03, 0);
    lit("sra_hib", 8'hE4, 0);
    load(0, 8'h03, 0); load(1, 8'h05, 0);
    load(2, 8'h24, 0); lit("and", 8'h01, 0);
    load(2, 8'h25, 0); lit("or", 8'h07, 0);
    load(2, 8'h26, 0); lit("xor", 8'h06, 0);
    load(2, 8'h27, 0); lit("nor", 8'hF8, 0);
    load(2, 8'h20, 0); lit("add_again", 8'h08, 0);
    load(3, 8'hA5, 0); lit("acc1", 8'h0D, 0);
    load(3, 8'h00, 1); lit("acc2", 8'h12, 0);
    load(2, 8'h3F, 0); lit("invalid", 8'h00, 3'b001);
    load(2, 8'h20, 0);

    // Reset lands in the compute cycle: no pulse, async clear.
    @(negedge clk);
    i_sel = 2'b00; i_dato = 8'h55; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    i_rst  = 1'b1;
    #1;
    lit("rst_abort", 0, 0);
    check("rst_abort_valid", int'(o_valid), 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); i_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    load(1, 8'h05, 0);
    lit("post_rst", 8'h05, 0);

    for (int i = 0; i < 300; i++) begin
      int sel, dato;
      sel  = $urandom_range(0, 3);
      dato = $urandom_range(0, 255);
      if (sel == 2 && $urandom_range(0, 7) != 0)
        dato = ops[$urandom_range(0, 7)] + 64 * $urandom_range(0, 3);
      load(sel, dato, $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
